idli_fetch_m: RTL and testbench

IDLI_FETCH_M -- requirements
Module: idli_fetch_m

---
 rtl/idli_pkg.sv | 24 ++
 rtl/idli_fetch_m.sv | 121 ++++++++++++
 tb/tb_idli_fetch_m.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core front end.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData
  } fch_state_t;

  localparam logic [7:0]  SQI_CMD_READ     = 8'h03;
  localparam int unsigned FCH_DUMMY_CYCLES = 2;

  // Nibble idx (0 = most significant) of a 24-bit SQI byte address.
  function automatic sqi_data_t addr_nibble(input logic [23:0] addr, input logic [2:0] idx);
    logic [23:0] sh;
    sh = addr << {idx, 2'b00};
    return sh[23:20];
  endfunction

endpackage

// File: rtl/idli_fetch_m.sv
// Instruction fetch: streams 16-bit instructions as nibbles from an SQI memory using
// continuous read mode, restarting the read on redirect or address wrap.
module idli_fetch_m
  import idli_pkg::*;
(
  input  logic        i_fch_gck,
  input  logic        i_fch_rst,
  input  sqi_data_t   i_fch_sio,
  output sqi_data_t   o_fch_sio,
  output logic        o_fch_sio_oe,
  output logic        o_fch_cs_n,
  output logic        o_fch_sck_en,
  input  logic        i_fch_stall,
  input  logic        i_fch_redir,
  input  logic [15:0] i_fch_redir_pc,
  output sqi_data_t   o_fch_enc,
  output logic        o_fch_enc_vld,
  output logic [15:0] o_fch_pc
);

  fch_state_t  state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [1:0]  nib_q, nib_d;
  logic [15:0] pc_q, pc_d;
  logic [23:0] byte_addr;

  assign byte_addr = {7'b0, pc_q, 1'b0};
  assign o_fch_pc  = pc_q;

  always_ff @(posedge i_fch_gck or posedge i_fch_rst) begin
    if (i_fch_rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      nib_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      nib_q   <= nib_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    nib_d         = nib_q;
    pc_d          = pc_q;
    o_fch_sio     = '0;
    o_fch_sio_oe  = 1'b0;
    o_fch_cs_n    = 1'b1;
    o_fch_sck_en  = 1'b0;
    o_fch_enc     = '0;
    o_fch_enc_vld = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StCmd;
        phase_d = '0;
      end
      StCmd: begin
        o_fch_cs_n   = 1'b0;
        o_fch_sio_oe = 1'b1;
        o_fch_sck_en = 1'b1;
        o_fch_sio    = phase_q[0] ? SQI_CMD_READ[3:0] : SQI_CMD_READ[7:4];
        if (phase_q == 3'd1) begin
          state_d = StAddr;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      StAddr: begin
        o_fch_cs_n   = 1'b0;
        o_fch_sio_oe = 1'b1;
        o_fch_sck_en = 1'b1;
        o_fch_sio    = addr_nibble(byte_addr, phase_q);
        if (phase_q == 3'd5) begin
          state_d = StDummy;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      StDummy: begin
        o_fch_cs_n   = 1'b0;
        o_fch_sck_en = 1'b1;
        if (phase_q == 3'(FCH_DUMMY_CYCLES - 1)) begin
          state_d = StData;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      StData: begin
        // Stall freezes the memory clock so the current nibble is simply held.
        o_fch_cs_n    = 1'b0;
        o_fch_enc     = i_fch_sio;
        o_fch_enc_vld = !i_fch_stall;
        o_fch_sck_en  = !i_fch_stall;
        if (!i_fch_stall) begin
          nib_d = nib_q + 2'd1;
          if (nib_q == 2'd3) begin
            pc_d = pc_q + 16'd1;
            if (pc_q == 16'hFFFF) state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (i_fch_redir) begin
      pc_d          = i_fch_redir_pc;
      phase_d       = '0;
      nib_d         = '0;
      state_d       = StIdle;
      o_fch_enc_vld = 1'b0;
    end
  end

endmodule

// File: tb/tb_idli_fetch_m.sv
// Bench for idli_fetch_m: SQI memory model plus an expected-nibble scoreboard.
module tb_idli_fetch_m;
  import idli_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  sqi_data_t   sio_in;
  sqi_data_t   sio_out;
  logic        sio_oe, cs_n, sck_en, stall, redir, vld;
  logic [15:0] redir_pc, pc;
  sqi_data_t   enc;

  always #5 clk = ~clk;

  idli_fetch_m dut (
    .i_fch_gck      (clk),
    .i_fch_rst      (rst),
    .i_fch_sio      (sio_in),
    .o_fch_sio      (sio_out),
    .o_fch_sio_oe   (sio_oe),
    .o_fch_cs_n     (cs_n),
    .o_fch_sck_en   (sck_en),
    .i_fch_stall    (stall),
    .i_fch_redir    (redir),
    .i_fch_redir_pc (redir_pc),
    .o_fch_enc      (enc),
    .o_fch_enc_vld  (vld),
    .o_fch_pc       (pc)
  );

  typedef struct packed {
    logic [3:0]  enc;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] addr_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_seen   = 0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] data, input logic [15:0] wpc);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.enc = data[15 - 4*i -: 4];
      e.pc  = wpc;
      sb_q.push_back(e);
    end
  endtask

  // SQI memory model: word w holds w ^ 16'hB7F7, read data streams sequentially.
  int          m_cnt = 0;
  int          m_di;
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_addr = '0;
  logic [15:0] m_word, m_sh;

  always @(posedge clk) begin
    if (cs_n) begin
      m_cnt <= 0;
    end else if (sck_en) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt < 2) m_cmd <= {m_cmd[3:0], sio_out};
      else if (m_cnt < 8) m_addr <= {m_addr[19:0], sio_out};
      if (m_cnt == 7) begin
        check("read command", {24'h0, m_cmd}, 32'h03);
        if (addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read address: got %0h, expected no read", {m_addr[19:0], sio_out});
        end else begin
          check("read address", {8'h0, m_addr[19:0], sio_out}, {8'h0, addr_q.pop_front()});
        end
      end
    end
  end

  always_comb begin
    m_di   = m_cnt - 10;
    m_word = '0;
    m_sh   = '0;
    sio_in = '0;
    if (m_cnt >= 10) begin
      m_word = (m_addr[16:1] + 16'(m_di / 4)) ^ 16'hB7F7;
      m_sh   = m_word << (4 * (m_di % 4));
      sio_in = m_sh[15:12];
    end
  end

  // Monitor: every delivered nibble must match the head of the scoreboard.
  always @(negedge clk) begin
    if (vld) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL enc nibble: got enc=%0h pc=%0h, expected none", enc, pc);
      end else begin
        mon_e = sb_q.pop_front();
        check("enc nibble {enc,pc}", {12'h0, enc, pc}, {12'h0, mon_e.enc, mon_e.pc});
      end
      n_seen++;
    end
  end

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) break;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_empty: got %0d pending, expected 0", sb_q.size());
    end
  endtask

  task automatic wait_seen(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (n_seen >= target) break;
    end
    if (n_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_seen: got %0d, expected %0d", n_seen, target);
    end
  endtask

  task automatic wait_cnt(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (m_cnt == target) break;
    end
    if (m_cnt != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cnt: got %0d, expected %0d", m_cnt, target);
    end
  endtask

  int first_vld;
  int base;

  initial begin
    stall    = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset cs_n", {31'h0, cs_n}, 32'h1);
    check("reset sio_oe", {31'h0, sio_oe}, 32'h0);
    check("reset sck_en", {31'h0, sck_en}, 32'h0);
    check("reset enc_vld", {31'h0, vld}, 32'h0);
    check("reset sio", {28'h0, sio_out}, 32'h0);
    check("reset pc", {16'h0, pc}, 32'h0);

    // Fetch from pc 0 after reset release
    addr_q.push_back(24'h000000);
    push_word(16'hB7F7, 16'h0000);
    push_word(16'hB7F6, 16'h0001);
    @(posedge clk);
    #1 rst = 1'b0;
    first_vld = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) check("idle cs_n", {31'h0, cs_n}, 32'h1);
      if (c == 10) check("dummy {oe,cs_n,sck_en}", {29'h0, sio_oe, cs_n, sck_en}, 32'h1);
      if (vld) begin
        first_vld = c;
        break;
      end
    end
    check("first enc_vld cycle", first_vld, 32'd11);
    wait_empty(100);

    // Redirect to 16'h1234 and stall after the 2nd nibble
    redir    = 1'b1;
    redir_pc = 16'h1234;
    addr_q.push_back(24'h002468);
    push_word(16'hA5C3, 16'h1234);
    push_word(16'hA5C2, 16'h1235);
    @(negedge clk);
    check("redirect enc_vld", {31'h0, vld}, 32'h0);
    @(posedge clk);
    #1 redir = 1'b0;
    base = n_seen;
    @(negedge clk);
    check("redirect pc", {16'h0, pc}, 32'h1234);
    wait_seen(base + 2, 100);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall {vld,sck_en}", {30'h0, vld, sck_en}, 32'h0);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    wait_empty(100);

    // Redirect at ADDR nibble 3 together with stall
    redir    = 1'b1;
    redir_pc = 16'h4321;
    @(posedge clk);
    #1 redir = 1'b0;
    wait_cnt(5, 40);
    redir    = 1'b1;
    redir_pc = 16'h0BEE;
    stall    = 1'b1;
    addr_q.push_back(24'h0017DC);
    push_word(16'hBC19, 16'h0BEE);
    @(negedge clk);
    check("addr nibble 3 {oe,sio}", {27'h0, sio_oe, sio_out}, 32'h16);
    check("addr redirect enc_vld", {31'h0, vld}, 32'h0);
    @(posedge clk);
    #1 redir = 1'b0;
    @(negedge clk);
    check("redirect idle {cs_n,pc}", {15'h0, cs_n, pc}, 32'h10BEE);
    @(negedge clk);
    check("cmd under stall {cs_n,oe,sck}", {29'h0, cs_n, sio_oe, sck_en}, 32'h3);
    repeat (4) @(posedge clk);
    #1 stall = 1'b0;
    wait_empty(100);

    // Wrap from 16'hFFFF
    redir    = 1'b1;
    redir_pc = 16'hFFFF;
    addr_q.push_back(24'h01FFFE);
    addr_q.push_back(24'h000000);
    push_word(16'h4808, 16'hFFFF);
    push_word(16'hB7F7, 16'h0000);
    base = n_seen;
    @(posedge clk);
    #1 redir = 1'b0;
    wait_seen(base + 4, 100);
    @(negedge clk);
    check("wrap idle {cs_n,pc}", {15'h0, cs_n, pc}, 32'h10000);
    @(negedge clk);
    check("wrap reissue cs_n", {31'h0, cs_n}, 32'h0);

    // Reset pulse while the 2nd nibble is on the bus
    wait_seen(base + 5, 100);
    rst = 1'b1;
    #1;
    check("mid reset {cs_n,vld,sck,sio}", {25'h0, cs_n, vld, sck_en, sio_out}, 32'h40);
    check("mid reset pc", {16'h0, pc}, 32'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    addr_q.push_back(24'h000000);
    push_word(16'hB7F7, 16'h0000);
    wait_empty(100);
    rst = 1'b1;
    #1;
    check("final addr_q drained", addr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
